// File: rtl/ula_iterativa_if.sv
// rtl/ula_iterativa_if.sv - start/done handshake, operands and result of the ULA
interface ula_iterativa_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ula_select;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             done;
  logic             busy;

  modport master (
    output start, ula_select, a, b,
    input  result, zero, done, busy
  );

  modport slave (
    input  start, ula_select, a, b,
    output result, zero, done, busy
  );
endinterface

// File: rtl/ula_iterativa.sv
// rtl/ula_iterativa.sv - RV32I ULA; shifts run SHIFT_STEP bits per cycle.
// ULA_FAST_SHIFT_EN builds a single-cycle barrel shifter instead of the SHIFT state.
module ula_iterativa #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  ula_iterativa_if.slave bus
);
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_AND   = 4'b1010;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_AUIPC = 4'b1100;

  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             w_busy;

  assign w_shamt = bus.b[4:0];

  always_comb begin
    w_alu = '0;
    case (bus.ula_select)
      OP_ADD:   w_alu = bus.a + bus.b;
      OP_SUB:   w_alu = bus.a - bus.b;
      OP_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU:  w_alu = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_XOR:   w_alu = bus.a ^ bus.b;
      OP_OR:    w_alu = bus.a | bus.b;
      OP_AND:   w_alu = bus.a & bus.b;
      OP_LUI:   w_alu = bus.b;
      OP_AUIPC: w_alu = bus.a + bus.b;
`ifdef ULA_FAST_SHIFT_EN
      OP_SLL:   w_alu = bus.a << w_shamt;
      OP_SRL:   w_alu = bus.a >> w_shamt;
      OP_SRA:   w_alu = $signed(bus.a) >>> w_shamt;
`else
      // Only reached with shamt=0; nonzero shifts go through the SHIFT state
      OP_SLL, OP_SRL, OP_SRA: w_alu = bus.a;
`endif
      default:  w_alu = '0;
    endcase
  end

`ifdef ULA_FAST_SHIFT_EN
  assign w_busy = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= bus.start;
      if (bus.start) r_result <= w_alu;
    end
  end
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_shreg;
  logic [5:0]         r_cnt;
  logic [3:0]         r_op;
  logic               r_sign;
  logic               w_is_shift;
  logic               w_accept;
  logic               w_launch;
  logic               w_last;
  logic [5:0]         w_step;
  logic [2*WIDTH-1:0] w_ext;
  logic [WIDTH-1:0]   w_shifted;

  assign w_is_shift = (bus.ula_select == OP_SLL) || (bus.ula_select == OP_SRL) ||
                      (bus.ula_select == OP_SRA);
  assign w_accept   = bus.start && (r_state == S_IDLE);
  assign w_launch   = w_accept && w_is_shift && (w_shamt != 5'd0);
  assign w_step     = (r_cnt < STEP) ? r_cnt : STEP;
  assign w_last     = (r_state == S_SHIFT) && (r_cnt == w_step);
  // Sign-extended copy so SRA fills with the captured sign, not the live operand
  assign w_ext      = {{WIDTH{r_sign}}, r_shreg} >> w_step;
  assign w_busy     = (r_state == S_SHIFT);

  always_comb begin
    w_shifted = w_ext[WIDTH-1:0];
    case (r_op)
      OP_SLL:  w_shifted = r_shreg << w_step;
      OP_SRL:  w_shifted = r_shreg >> w_step;
      default: w_shifted = w_ext[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_SHIFT;
      S_SHIFT: if (w_last)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_done   <= 1'b0;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sign   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_launch) begin
          r_shreg <= bus.a;
          r_cnt   <= {1'b0, w_shamt};
          r_op    <= bus.ula_select;
          r_sign  <= bus.a[WIDTH-1];
        end else begin
          r_result <= w_alu;
          r_done   <= 1'b1;
        end
      end else if (r_state == S_SHIFT) begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt - w_step;
        if (w_last) begin
          r_result <= w_shifted;
          r_done   <= 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    bus.result = r_result;
    bus.zero   = (r_result == '0);
    bus.done   = r_done;
    bus.busy   = w_busy;
  end
endmodule

// File: tb/tb_ula_iterativa.sv
// tb/tb_ula_iterativa.sv - directed and random checks of ula_iterativa, SHIFT_STEP 1 and 4
module tb_ula_iterativa;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ula_iterativa_if #(.WIDTH(32)) bus1 ();
  ula_iterativa_if #(.WIDTH(32)) bus4 ();

  ula_iterativa #(.WIDTH(32), .SHIFT_STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ula_iterativa #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (sel)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a << sh;
      4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a >> sh;
      4'd7:  return a[31] ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
      4'd8:  return a ^ b;
      4'd9:  return a | b;
      4'd10: return a & b;
      4'd11: return b;
      4'd12: return a + b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] sel, input logic [31:0] b, input int step);
`ifdef ULA_FAST_SHIFT_EN
    return 1;
`else
    if ((sel == 4'd3 || sel == 4'd6 || sel == 4'd7) && b[4:0] != 5'd0)
      return 1 + (int'(b[4:0]) + step - 1) / step;
    return 1;
`endif
  endfunction

  // Reference: per unit, cycles left until done plus the pending and visible result
  int          m_rem[2]  = '{0, 0};
  logic [31:0] m_pend[2] = '{32'd0, 32'd0};
  logic [31:0] m_res[2]  = '{32'd0, 32'd0};
  logic        m_done[2] = '{1'b0, 1'b0};
  int          steps[2]  = '{1, 4};

  always @(posedge clk or posedge rst) begin
    int l;
    logic [31:0] r;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_rem[k]  = 0;
        m_res[k]  = 32'd0;
        m_done[k] = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        if (m_rem[k] > 0) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_res[k]  = m_pend[k];
            m_done[k] = 1'b1;
          end
        end else if (bus1.start) begin
          l = exp_lat(bus1.ula_select, bus1.b, steps[k]);
          r = ref_alu(bus1.ula_select, bus1.a, bus1.b);
          if (l == 1) begin
            m_res[k]  = r;
            m_done[k] = 1'b1;
          end else begin
            m_rem[k]  = l - 1;
            m_pend[k] = r;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("res1", bus1.result, m_res[0]);
    chk("zero1", bus1.zero, m_res[0] == 32'd0);
    chk("done1", bus1.done, m_done[0]);
    chk("busy1", bus1.busy, m_rem[0] > 0);
    chk("res4", bus4.result, m_res[1]);
    chk("zero4", bus4.zero, m_res[1] == 32'd0);
    chk("done4", bus4.done, m_done[1]);
    chk("busy4", bus4.busy, m_rem[1] > 0);
    chk("done_busy_excl", bus1.done & bus1.busy | bus4.done & bus4.busy, 1'b0);
  end

  task automatic set_in(input logic s, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b);
    bus1.start = s; bus1.ula_select = sel; bus1.a = a; bus1.b = b;
    bus4.start = s; bus4.ula_select = sel; bus4.a = a; bus4.b = b;
  endtask

  // Starts one op at the current negedge; returns at the negedge of the later done
  task automatic do_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input bit junk);
    int l1, l4, lmin, c, seen1, seen4;
    logic [31:0] got1, got4;
    l1 = exp_lat(sel, b, 1);
    l4 = exp_lat(sel, b, 4);
    lmin = (l1 < l4) ? l1 : l4;
    c = 0; seen1 = 0; seen4 = 0; got1 = 32'd0; got4 = 32'd0;
    set_in(1'b1, sel, a, b);
    while ((seen1 == 0 || seen4 == 0) && c < 60) begin
      @(negedge clk);
      c++;
      if (junk && c < lmin)
        set_in(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
      else
        set_in(1'b0, sel, a, b);
      if (bus1.done && seen1 == 0) begin seen1 = c; got1 = bus1.result; end
      if (bus4.done && seen4 == 0) begin seen4 = c; got4 = bus4.result; end
    end
    chk({name, "_lat1"}, seen1, l1);
    chk({name, "_lat4"}, seen4, l4);
    chk({name, "_res1"}, got1, exp_res);
    chk({name, "_res4"}, got4, exp_res);
  endtask

  initial begin
    int cnt;
    logic [31:0] rb;
    set_in(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_res", bus1.result | bus4.result, 32'd0);
    chk("rst_zero", bus1.zero & bus4.zero, 1'b1);
    chk("rst_done", bus1.done | bus4.done, 1'b0);
    chk("rst_busy", bus1.busy | bus4.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_wrap", 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    chk("add_zero", bus1.zero, 1'b1);
    do_op("sub", 4'b0010, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
    do_op("slt", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    do_op("sltu", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    do_op("undef", 4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0);
    do_op("sra4", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
    do_op("srl4", 4'b0110, 32'h8000_0000, 32'd4, 32'h0800_0000, 0);
    do_op("xor_b2b", 4'b1000, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 0);
    do_op("sll31", 4'b0011, 32'd1, 32'd31, 32'h8000_0000, 1);
    do_op("sll0", 4'b0011, 32'd1, 32'd0, 32'd1, 0);
    do_op("sra31", 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1);
    do_op("lui", 4'b1011, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 0);
    do_op("auipc", 4'b1100, 32'h0000_1000, 32'hFFFF_F000, 32'd0, 0);
    do_op("and", 4'b1010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
    do_op("or", 4'b1001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0);

    set_in(1'b1, 4'b0011, 32'd1, 32'd31);
    repeat (5) begin
      @(negedge clk);
      set_in(1'b0, 4'b0011, 32'd1, 32'd31);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_res", bus1.result | bus4.result, 32'd0);
    chk("abort_zero", bus1.zero & bus4.zero, 1'b1);
    chk("abort_busy", bus1.busy | bus4.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.done || bus4.done) cnt++;
    end
    chk("abort_nodone", cnt, 0);

    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb[4:0] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
      set_in($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom, rb);
    end
    @(negedge clk);
    set_in(1'b0, 4'd0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
